// File: rtl/cluster_frame_encoder_if.sv
// -----------------------------------------------------------------------------
// cluster_frame_encoder_if
// Bundles the truncator-side input word and the frame-side outputs of the
// cluster frame encoder.
//   vpfs_in       : 768-bit truncator output, bit n = cluster at address n
//   pass_in       : truncator pass number aligned with vpfs_in (0 = first word)
//   clusters_out  : eight 10-bit cluster addresses, slot k at [10k+9:10k]
//   cluster_count : number of valid slots (0..8)
//   overflow      : more clusters were present than slots
//   frame_valid   : one-cycle strobe marking a freshly loaded frame
// Modports: master drives the word and receives the frame; slave is the encoder.
// -----------------------------------------------------------------------------
interface cluster_frame_encoder_if #(
   parameter int VPF_W      = 768,
   parameter int ADR_W      = 10,
   parameter int MXCLUSTERS = 8,
   parameter int CNT_W      = 4
);
   logic [VPF_W-1:0]            vpfs_in;
   logic [$clog2(MXCLUSTERS)-1:0] pass_in;
   logic [MXCLUSTERS*ADR_W-1:0] clusters_out;
   logic [CNT_W-1:0]            cluster_count;
   logic                        overflow;
   logic                        frame_valid;

   modport master (
      output vpfs_in, pass_in,
      input  clusters_out, cluster_count, overflow, frame_valid
   );

   modport slave (
      input  vpfs_in, pass_in,
      output clusters_out, cluster_count, overflow, frame_valid
   );
endinterface

// File: rtl/cluster_frame_encoder.sv
// -----------------------------------------------------------------------------
// cluster_frame_encoder
// Priority-encodes the lowest set bit of each truncator word into a 10-bit
// cluster address and gathers the eight addresses of one 8-pass frame.
//   clock   : 160 MHz clock
//   reset_n : asynchronous active-low reset
//   bus     : cluster_frame_encoder_if.slave (vpfs_in/pass_in in,
//             clusters_out/cluster_count/overflow/frame_valid out)
// Pipeline: E0 registers per-segment find-first, E1 registers the selected
// address, E2 updates the slot array and, on pass 7 of an open frame, the
// output frame with a one-cycle frame_valid strobe.
// -----------------------------------------------------------------------------
module cluster_frame_encoder #(
   parameter int          MXSEGS      = 12,
   parameter int          SEGSIZE     = 64,
   parameter int          MXCLUSTERS  = 8,
   parameter logic [9:0]  INVALID_ADR = 10'h3FF
) (
   input logic                    clock,
   input logic                    reset_n,
   cluster_frame_encoder_if.slave bus
);
   localparam int POS_W  = $clog2(SEGSIZE);
   localparam int SEG_W  = $clog2(MXSEGS);
   localparam int ADR_W  = SEG_W + POS_W;
   localparam int PASS_W = $clog2(MXCLUSTERS);
   localparam int CNT_W  = $clog2(MXCLUSTERS + 1);
   localparam logic [PASS_W-1:0] FIRST_PASS = '0;
   localparam logic [PASS_W-1:0] LAST_PASS  = PASS_W'(MXCLUSTERS - 1);

   // ---------------- stage 1: per-segment find-first ----------------
   logic [MXSEGS-1:0] w_seg_any;
   logic [MXSEGS-1:0] w_seg_multi;
   logic [POS_W-1:0]  w_seg_pos [MXSEGS];

   for (genvar g = 0; g < MXSEGS; g++) begin : g_seg
      logic [SEGSIZE-1:0] w_bits;
      assign w_bits         = bus.vpfs_in[g*SEGSIZE +: SEGSIZE];
      assign w_seg_any[g]   = |w_bits;
      // Clearing the lowest set bit leaves something only if two or more were set.
      assign w_seg_multi[g] = |(w_bits & (w_bits - SEGSIZE'(1)));
   end

   // NOTE: every combinational output gets a default before any condition, so
   // no path leaves it unassigned and no latch is inferred.
   always_comb begin
      for (int s = 0; s < MXSEGS; s++) begin
         w_seg_pos[s] = '0;
         // Scanning downwards lets the lowest set bit win the last assignment.
         for (int b = SEGSIZE - 1; b >= 0; b--) begin
            if (bus.vpfs_in[s*SEGSIZE + b]) w_seg_pos[s] = POS_W'(b);
         end
      end
   end

   logic                r_s1_valid;
   logic [PASS_W-1:0]   r_s1_pass;
   logic [MXSEGS-1:0]   r_seg_any;
   logic [MXSEGS-1:0]   r_seg_multi;
   logic [POS_W-1:0]    r_seg_pos [MXSEGS];

   // NOTE: clocked state uses non-blocking assignments so every register
   // samples the pre-edge values and pipeline order does not matter.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s1_valid  <= 1'b0;
         r_s1_pass   <= '0;
         r_seg_any   <= '0;
         r_seg_multi <= '0;
         for (int s = 0; s < MXSEGS; s++) r_seg_pos[s] <= '0;
      end else begin
         // No input valid exists; this bit only masks the reset contents.
         r_s1_valid  <= 1'b1;
         r_s1_pass   <= bus.pass_in;
         r_seg_any   <= w_seg_any;
         r_seg_multi <= w_seg_multi;
         for (int s = 0; s < MXSEGS; s++) r_seg_pos[s] <= w_seg_pos[s];
      end
   end

   // ---------------- stage 2: segment select ----------------
   logic             w_hit;
   logic             w_found;
   logic             w_more;
   logic [SEG_W-1:0] w_sel;
   logic [POS_W-1:0] w_pos;
   logic [ADR_W-1:0] w_adr;

   always_comb begin
      w_hit   = |r_seg_any;
      w_found = 1'b0;
      w_more  = 1'b0;
      w_sel   = '0;
      w_pos   = '0;
      for (int s = 0; s < MXSEGS; s++) begin
         if (r_seg_any[s]) begin
            if (!w_found) begin
               w_found = 1'b1;
               w_sel   = SEG_W'(s);
               w_pos   = r_seg_pos[s];
               w_more  = r_seg_multi[s];
            end else begin
               w_more  = 1'b1;   // any hit above the selected segment
            end
         end
      end
      // s*64 + pos is a plain concatenation because SEGSIZE is a power of two.
      w_adr = w_hit ? {w_sel, w_pos} : INVALID_ADR;
   end

   logic              r_s2_valid;
   logic [PASS_W-1:0] r_s2_pass;
   logic              r_s2_hit;
   logic              r_s2_more;
   logic [ADR_W-1:0]  r_s2_adr;

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_s2_valid <= 1'b0;
         r_s2_pass  <= '0;
         r_s2_hit   <= 1'b0;
         r_s2_more  <= 1'b0;
         r_s2_adr   <= INVALID_ADR;
      end else begin
         r_s2_valid <= r_s1_valid;
         r_s2_pass  <= r_s1_pass;
         r_s2_hit   <= w_hit;
         r_s2_more  <= w_more;
         r_s2_adr   <= w_adr;
      end
   end

   // ---------------- assembly ----------------
   logic [ADR_W-1:0]            r_slot [MXCLUSTERS];
   logic [CNT_W-1:0]            r_count;
   logic                        r_frame_open;
   logic [MXCLUSTERS*ADR_W-1:0] r_clusters;
   logic [CNT_W-1:0]            r_cluster_count;
   logic                        r_overflow;
   logic                        r_frame_valid;

   logic [ADR_W-1:0] w_slot_nxt [MXCLUSTERS];
   logic [CNT_W-1:0] w_count_nxt;
   logic             w_first;

   always_comb begin
      w_first = (r_s2_pass == FIRST_PASS);
      for (int k = 0; k < MXCLUSTERS; k++)
         w_slot_nxt[k] = w_first ? INVALID_ADR : r_slot[k];
      w_slot_nxt[r_s2_pass] = r_s2_adr;
      w_count_nxt = (w_first ? '0 : r_count) + CNT_W'(r_s2_hit);
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the slot array is only eight entries, so it is reset like any
         // register; empty slots must read INVALID_ADR from the first frame on.
         for (int k = 0; k < MXCLUSTERS; k++) r_slot[k] <= INVALID_ADR;
         r_count         <= '0;
         r_frame_open    <= 1'b0;
         r_clusters      <= {MXCLUSTERS{INVALID_ADR}};
         r_cluster_count <= '0;
         r_overflow      <= 1'b0;
         r_frame_valid   <= 1'b0;
      end else begin
         r_frame_valid <= 1'b0;
         if (r_s2_valid) begin
            for (int k = 0; k < MXCLUSTERS; k++) r_slot[k] <= w_slot_nxt[k];
            r_count <= w_count_nxt;
            if (w_first) begin
               r_frame_open <= 1'b1;
            end else if (r_s2_pass == LAST_PASS && r_frame_open) begin
               r_frame_open    <= 1'b0;
               r_frame_valid   <= 1'b1;
               r_cluster_count <= w_count_nxt;
               r_overflow      <= r_s2_more;
               for (int k = 0; k < MXCLUSTERS; k++)
                  r_clusters[k*ADR_W +: ADR_W] <= w_slot_nxt[k];
            end
         end
      end
   end

   assign bus.clusters_out  = r_clusters;
   assign bus.cluster_count = r_cluster_count;
   assign bus.overflow      = r_overflow;
   assign bus.frame_valid   = r_frame_valid;

endmodule

// File: tb/tb_cluster_frame_encoder.sv
// -----------------------------------------------------------------------------
// tb_cluster_frame_encoder
// Directed frames for the cluster frame encoder. A behavioural model computes,
// for every word sampled, the lowest set bit and the population of the whole
// 768-bit vector, applies the frame rules, and delays the resulting frame by
// two clocks. The outputs are compared with it on every falling edge; literal
// expectations per scenario pin the model itself.
// -----------------------------------------------------------------------------
module tb_cluster_frame_encoder;
   localparam logic [79:0] ALL_INV = {8{10'h3FF}};

   logic clock   = 1'b0;
   logic reset_n = 1'b0;

   cluster_frame_encoder_if bus ();

   cluster_frame_encoder dut (
      .clock   (clock),
      .reset_n (reset_n),
      .bus     (bus)
   );

   always #5 clock = ~clock;

   int n_vec = 0;
   int n_bad = 0;
   int strobes = 0;
   logic [79:0] cap_clusters = ALL_INV;
   logic [3:0]  cap_count    = '0;
   logic        cap_ovf      = 1'b0;

   task automatic check(input string name, input logic [85:0] act, input logic [85:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   bit          m_open = 1'b0;
   int          m_slots [8];
   int          m_cnt = 0;
   bit          dly_strobe [2] = '{1'b0, 1'b0};
   logic [84:0] dly_data   [2];
   bit          cur_fv   = 1'b0;
   logic [84:0] cur_data = {1'b0, 4'd0, ALL_INV};

   function automatic logic [79:0] pack8(input int s [8]);
      logic [79:0] r;
      for (int k = 0; k < 8; k++) r[k*10 +: 10] = 10'(s[k]);
      return r;
   endfunction

   task automatic model_reset();
      m_open = 1'b0;
      m_cnt  = 0;
      for (int k = 0; k < 8; k++) m_slots[k] = 'h3FF;
      dly_strobe[0] = 1'b0;
      dly_strobe[1] = 1'b0;
      cur_fv   = 1'b0;
      cur_data = {1'b0, 4'd0, ALL_INV};
   endtask

   task automatic model_step(input logic [767:0] vec, input int p);
      int          low = -1;
      int          pop = 0;
      bit          new_strobe = 1'b0;
      logic [84:0] new_data = '0;
      for (int i = 0; i < 768; i++) begin
         if (vec[i]) begin
            pop++;
            if (low < 0) low = i;
         end
      end
      if (p == 0) begin
         for (int k = 0; k < 8; k++) m_slots[k] = 'h3FF;
         m_cnt  = 0;
         m_open = 1'b1;
      end
      m_slots[p] = (pop > 0) ? low : 'h3FF;
      if (pop > 0) m_cnt++;
      if (p == 7 && m_open) begin
         new_strobe = 1'b1;
         new_data   = {pop > 1, 4'(m_cnt), pack8(m_slots)};
         m_open     = 1'b0;
      end
      // Result of this sample reaches the outputs two edges later.
      cur_fv = dly_strobe[1];
      if (dly_strobe[1]) cur_data = dly_data[1];
      dly_strobe[1] = dly_strobe[0];
      dly_data[1]   = dly_data[0];
      dly_strobe[0] = new_strobe;
      dly_data[0]   = new_data;
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clock) begin
      check("outputs", {bus.frame_valid, bus.overflow, bus.cluster_count, bus.clusters_out},
            {cur_fv, cur_data});
      if (bus.frame_valid === 1'b1) begin
         strobes++;
         cap_clusters = bus.clusters_out;
         cap_count    = bus.cluster_count;
         cap_ovf      = bus.overflow;
      end
   end

   // ---------------- stimulus ----------------
   // Called away from the rising edge; drives, lets one edge sample, updates the model.
   task automatic step_word(input logic [767:0] vec, input int p);
      bus.vpfs_in = vec;
      bus.pass_in = 3'(p);
      @(posedge clock);
      model_step(vec, p);
      @(negedge clock);
   endtask

   function automatic logic [767:0] trunc_word(input int addrs [$], input int p);
      logic [767:0] v = '0;
      for (int i = p; i < addrs.size(); i++) v[addrs[i]] = 1'b1;
      return v;
   endfunction

   // The truncator removes the lowest remaining cluster after every pass.
   task automatic run_passes(input int addrs [$], input int first, input int last);
      int a [$] = addrs;
      a.sort();
      for (int p = first; p <= last; p++) step_word(trunc_word(a, p), p);
   endtask

   task automatic idle(input int n);
      repeat (n) step_word('0, 3);
   endtask

   task automatic expect_frame(input string name, input int es [8], input int ec,
                               input bit eo, input int n_strobes, input int s0);
      check({name, " slots"}, 86'(cap_clusters), 86'(pack8(es)));
      check({name, " count"}, 86'(cap_count), 86'(ec));
      check({name, " ovf"},   86'(cap_ovf), 86'(eo));
      check({name, " strobes"}, 86'(strobes - s0), 86'(n_strobes));
   endtask

   initial begin
      int q [$];
      int s0;
      int es [8];
      int bnd [4] = '{63, 64, 704, 767};

      model_reset();
      bus.vpfs_in = '0;
      bus.pass_in = '0;
      repeat (2) @(negedge clock);
      check("reset_state", {bus.frame_valid, bus.overflow, bus.cluster_count, bus.clusters_out},
            {2'b00, 4'd0, ALL_INV});
      reset_n = 1'b1;

      // Three clusters, with strobe latency pinned literally.
      s0 = strobes;
      q = '{767, 5, 64};
      run_passes(q, 0, 7);
      step_word('0, 3);
      check("lat_e1", 86'(bus.frame_valid), 86'(0));
      step_word('0, 3);
      check("lat_e2", 86'(bus.frame_valid), 86'(1));
      idle(1);
      expect_frame("three", '{5, 64, 767, 'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h3FF}, 3, 1'b0, 1, s0);

      // Overflow: ten clusters.
      s0 = strobes;
      q = '{0, 1, 2, 100, 200, 300, 400, 500, 600, 700};
      run_passes(q, 0, 7);
      idle(3);
      expect_frame("overflow", '{0, 1, 2, 100, 200, 300, 400, 500}, 8, 1'b1, 1, s0);

      // Empty frame.
      s0 = strobes;
      q = {};
      run_passes(q, 0, 7);
      idle(3);
      expect_frame("empty", '{'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h3FF}, 0, 1'b0, 1, s0);

      // Early restart: partial frame A abandoned by frame B.
      s0 = strobes;
      q = '{10, 20, 30, 40, 50};
      run_passes(q, 0, 3);
      q = '{3, 300, 600};
      run_passes(q, 0, 7);
      idle(3);
      expect_frame("restart", '{3, 300, 600, 'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h3FF}, 3, 1'b0, 1, s0);

      // Reset mid-frame at pass 4, then a stray 5..7 tail, then a full frame.
      s0 = strobes;
      q = '{7, 77, 707};
      run_passes(q, 0, 3);
      bus.vpfs_in = trunc_word(q, 4);
      bus.pass_in = 3'd4;
      #2 reset_n = 1'b0;
      model_reset();
      #1 check("reset_async", {bus.frame_valid, bus.overflow, bus.cluster_count, bus.clusters_out},
               {2'b00, 4'd0, ALL_INV});
      @(posedge clock);
      @(negedge clock);
      reset_n = 1'b1;
      run_passes(q, 5, 7);
      idle(3);
      check("partial_discard", 86'(strobes - s0), 86'(0));
      q = '{65, 128, 640};
      run_passes(q, 0, 7);
      idle(3);
      expect_frame("after_reset", '{65, 128, 640, 'h3FF, 'h3FF, 'h3FF, 'h3FF, 'h3FF}, 3, 1'b0, 1, s0);

      // Segment boundaries: single hits.
      foreach (bnd[i]) begin
         s0 = strobes;
         q = {};
         q.push_back(bnd[i]);
         run_passes(q, 0, 7);
         idle(3);
         for (int k = 0; k < 8; k++) es[k] = 'h3FF;
         es[0] = bnd[i];
         expect_frame($sformatf("boundary_%0d", bnd[i]), es, 1, 1'b0, 1, s0);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
